hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage RV32 pipeline.
- Generates stall and flush enables for the IF, IF/ID and ID/EX pipeline registers, and the EX-stage forwarding selects.
- Sequences multi-cycle EX operations (MUL/DIV unit) through a busy/done handshake, with a watchdog timeout.
- Sits beside the decode/execute registers and drives their enable and clear inputs; the ID/EX register gains an enable (StallE) and a synchronous clear (FlushE).

---
 rtl/pipe_pkg.sv | 18 +
 rtl/forward_unit.sv | 35 +++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the RV32 hazard control slice.
// Forwarding selects, hazard FSM states and result-source encodings.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding selects.
// Purely combinational; MEM result has priority over WB result.
module forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  output fwd_sel_t              ForwardAE,
  output fwd_sel_t              ForwardBE
);

  function automatic fwd_sel_t pick(
    input logic [REG_ADDR_W-1:0] rs
  );
    if (RegWriteM && (RdM != '0) && (RdM == rs))
      return FWD_MEM;
    else if (RegWriteW && (RdW != '0) && (RdW == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Select the freshest in-flight value for each operand
  always_comb begin
    ForwardAE = pick(Rs1E);
    ForwardBE = pick(Rs2E);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: stalls, flushes, forwarding, MUL/DIV wait.
// Optional perf counters when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter int MC_MAX_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [1:0]            ResultSrcE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  McStartE,
  input  logic                  McDone,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  McBusy,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           PerfStallCnt,
  output logic [31:0]           PerfFlushCnt,
`endif
  output logic                  McErr
);

  localparam int CNT_W = $clog2(MC_MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MC_MAX_CYCLES);

  hz_state_t        state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  fwd_sel_t         fa, fb;
  logic             lw_stall;

  forward_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd (
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardAE (fa),
    .ForwardBE (fb)
  );

  assign ForwardAE = rst ? fa : FWD_RF;
  assign ForwardBE = rst ? fb : FWD_RF;

  assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD)
                 && (RdE != '0)
                 && ((RdE == Rs1D) || (RdE == Rs2D));

  // Stall/flush decode and next-state for the multi-cycle wait
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    McBusy    = 1'b0;
    nxt_state = state;
    nxt_cnt   = cnt;
    if (rst) begin
      unique case (state)
        RUN: begin
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (McStartE && !McDone) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            nxt_state = MC_WAIT;
            nxt_cnt   = CNT_W'(1);
          end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MC_WAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          McBusy = 1'b1;
          if (cnt == CNT_MAX) begin
            FlushE    = 1'b1;
            nxt_state = RUN;
            nxt_cnt   = '0;
          end else if (McDone) begin
            nxt_state = RUN;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        default: nxt_state = RUN;
      endcase
    end
  end

  // FSM state, wait counter and the timeout pulse aligned to the abort cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
      McErr <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      McErr <= (nxt_state == MC_WAIT) && (nxt_cnt == CNT_MAX);
    end
  end

`ifdef HAZARD_PERF_EN
  // Free-running stall and flush event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PerfStallCnt <= '0;
      PerfFlushCnt <= '0;
    end else begin
      if (StallD) PerfStallCnt <= PerfStallCnt + 32'd1;
      if (FlushE) PerfFlushCnt <= PerfFlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with MC_MAX_CYCLES=4.
// Expected output vectors are queued at drive time and popped at sample time.
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, McStartE, McDone;
  logic       StallF, StallD, StallE, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       McBusy, McErr;
`ifdef HAZARD_PERF_EN
  logic [31:0] PerfStallCnt, PerfFlushCnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [10:0] sb[$];

  hazard_ctrl #(
    .REG_ADDR_W    (5),
    .MC_MAX_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .McStartE   (McStartE),
    .McDone     (McDone),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .McBusy     (McBusy),
`ifdef HAZARD_PERF_EN
    .PerfStallCnt (PerfStallCnt),
    .PerfFlushCnt (PerfFlushCnt),
`endif
    .McErr      (McErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {StallF,StallD,StallE,FlushD,FlushE,FwdA,FwdB,McBusy,McErr}
  function automatic logic [10:0] obs();
    return {StallF, StallD, StallE, FlushD, FlushE,
            ForwardAE, ForwardBE, McBusy, McErr};
  endfunction

  function automatic logic [10:0] ex(
    input bit sf, input bit sd, input bit se,
    input bit fd, input bit fe,
    input logic [1:0] fa, input logic [1:0] fb,
    input bit busy, input bit err
  );
    return {sf, sd, se, fd, fe, fa, fb, busy, err};
  endfunction

  function automatic logic [1:0] fmodel(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    RdM = 0; RdW = 0; ResultSrcE = 0;
    RegWriteM = 0; RegWriteW = 0;
    PCSrcE = 0; McStartE = 0; McDone = 0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    rst = 1'b0;
    idle();
    Rs1E = 5; RdM = 5; RegWriteM = 1;
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; McStartE = 1;
    sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
    #2;
    e = sb.pop_front();
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL reset_outputs got %b want %b", obs(), e);
    end
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    logic [10:0] e;
    for (int i = 0; i < 4; i++) begin
      idle();
      case (i)
        0: begin
          Rs1E = 5; Rs2E = 3; RdM = 5; RegWriteM = 1;
          RdW = 5; RegWriteW = 1;
          sb.push_back(ex(0,0,0,0,0,2'b10,2'b00,0,0));
        end
        1: begin
          Rs1E = 5; Rs2E = 3; RdM = 5; RegWriteM = 0;
          RdW = 5; RegWriteW = 1;
          sb.push_back(ex(0,0,0,0,0,2'b01,2'b00,0,0));
        end
        2: begin
          Rs1E = 0; Rs2E = 0; RdM = 0; RegWriteM = 1;
          RdW = 0; RegWriteW = 1;
          sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
        end
        default: begin
          Rs1E = 4; Rs2E = 9; RdM = 4; RegWriteM = 1;
          RdW = 9; RegWriteW = 1;
          sb.push_back(ex(0,0,0,0,0,2'b10,2'b01,0,0));
        end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL fwd_case%0d got %b want %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forward_random();
    logic [10:0] e;
    for (int i = 0; i < 16; i++) begin
      idle();
      Rs1E = 5'($urandom_range(0, 3));
      Rs2E = 5'($urandom_range(0, 3));
      RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      sb.push_back(ex(0,0,0,0,0,fmodel(Rs1E),fmodel(Rs2E),0,0));
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL fwd_rand%0d got %b want %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [10:0] e;
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin
          ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 2;
          sb.push_back(ex(1,1,0,0,1,2'b00,2'b00,0,0));
        end
        1: begin
          Rs2D = 7; Rs1D = 2;
          sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
        end
        default: begin
          ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0;
          sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
        end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL load_use%0d got %b want %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    logic [10:0] e;
    idle();
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1;
    sb.push_back(ex(0,0,0,1,1,2'b00,2'b00,0,0));
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL branch_over_lw got %b want %b", obs(), e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mc_done();
    logic [10:0] e;
    int busy_n = 0;
    int stall_n = 0;
    for (int i = 0; i < 7; i++) begin
      idle();
      case (i)
        0: begin
          McStartE = 1;
          sb.push_back(ex(1,1,1,0,0,2'b00,2'b00,0,0));
        end
        1, 2: sb.push_back(ex(1,1,1,0,0,2'b00,2'b00,1,0));
        3: begin
          McDone = 1;
          sb.push_back(ex(1,1,1,0,0,2'b00,2'b00,1,0));
        end
        4: sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
        5: begin
          McStartE = 1; McDone = 1;
          sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
        end
        default: sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
      endcase
      @(negedge clk);
      if (i < 5) begin
        busy_n  += int'(McBusy);
        stall_n += int'(StallE);
      end
      e = sb.pop_front();
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL mc_done%0d got %b want %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (busy_n != 3 || stall_n != 4) begin
      fails++;
      $display("FAIL mc_counts busy=%0d stallE=%0d want 3 4",
               busy_n, stall_n);
    end
  endtask

  task automatic test_mc_timeout();
    logic [10:0] e;
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin
          McStartE = 1;
          sb.push_back(ex(1,1,1,0,0,2'b00,2'b00,0,0));
        end
        2: begin
          PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
          sb.push_back(ex(1,1,1,0,0,2'b00,2'b00,1,0));
        end
        1, 3: sb.push_back(ex(1,1,1,0,0,2'b00,2'b00,1,0));
        4: sb.push_back(ex(1,1,1,0,1,2'b00,2'b00,1,1));
        default: sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
      endcase
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (obs() !== e) begin
        fails++;
        $display("FAIL mc_timeout%0d got %b want %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [10:0] e;
    idle();
    McStartE = 1;
    sb.push_back(ex(1,1,1,0,0,2'b00,2'b00,0,0));
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL rmid_start got %b want %b", obs(), e);
    end
    @(posedge clk); #1;
    idle();
    sb.push_back(ex(1,1,1,0,0,2'b00,2'b00,1,0));
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL rmid_wait got %b want %b", obs(), e);
    end
    #2;
    rst = 1'b0;
    McDone = 1;
    sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
    #1;
    e = sb.pop_front();
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL rmid_async got %b want %b", obs(), e);
    end
`ifdef HAZARD_PERF_EN
    tests++;
    if (PerfStallCnt !== 32'd0 || PerfFlushCnt !== 32'd0) begin
      fails++;
      $display("FAIL rmid_perf got %0d %0d want 0 0",
               PerfStallCnt, PerfFlushCnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL rmid_run got %b want %b", obs(), e);
    end
    @(posedge clk); #1;
    idle();
    sb.push_back(ex(0,0,0,0,0,2'b00,2'b00,0,0));
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (obs() !== e) begin
      fails++;
      $display("FAIL rmid_idle got %b want %b", obs(), e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_forward_random();
    test_load_use();
    test_branch_priority();
    test_mc_done();
    test_mc_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
